// File: rtl/matrix_stream_loader.sv
// Stream loader: takes a (rows, cols) header followed by rows*cols elements over
// valid/ready, checks the dimensions and writes the elements into BRAM from a base address.
module matrix_stream_loader #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int MAX_DIM       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     in_valid,
  input  logic [ELEMENT_WIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
  output logic [4:0]               dim_m,
  output logic [4:0]               dim_n,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_M, S_GET_N, S_CHECK, S_LOAD, S_DONE, S_ERR
  } state_t;

  localparam logic [ELEMENT_WIDTH-1:0] MAX_WORD = ELEMENT_WIDTH'(MAX_DIM);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [8:0]              idx;
  logic [8:0]              total;
  logic                    m_bad, n_bad;
  logic                    xfer;
  logic                    last;
  logic                    word_bad;

  assign in_ready = (state == S_GET_M) || (state == S_GET_N) || (state == S_LOAD);
  // A word accepted in the same cycle as abort is dropped entirely.
  assign xfer     = in_valid && in_ready && !abort;
  assign last     = (idx == total - 9'd1);
  // Range check uses the whole word so e.g. 0x22 is not mistaken for 2.
  assign word_bad = (in_data == '0) || (in_data > MAX_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_GET_M;
      S_GET_M: begin
        busy = 1'b1;
        if (xfer) state_nxt = S_GET_N;
      end
      S_GET_N: begin
        busy = 1'b1;
        if (xfer) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy      = 1'b1;
        state_nxt = (m_bad || n_bad) ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (xfer && last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) state_nxt = S_IDLE;
      end
      S_ERR: begin
        error = 1'b1;
        if (!start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      idx         <= '0;
      total       <= '0;
      m_bad       <= 1'b0;
      n_bad       <= 1'b0;
      dim_m       <= '0;
      dim_n       <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            base_q <= base_addr;
            idx    <= '0;
          end
        end
        S_GET_M: begin
          if (xfer) begin
            dim_m <= in_data[4:0];
            m_bad <= word_bad;
          end
        end
        S_GET_N: begin
          if (xfer) begin
            dim_n <= in_data[4:0];
            n_bad <= word_bad;
          end
        end
        S_CHECK: total <= 9'(dim_m) * 9'(dim_n);
        S_LOAD: begin
          if (xfer) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= base_q + ADDR_WIDTH'(idx);
            mem_wr_data <= in_data;
            if (!last) idx <= idx + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: header validation, loads with and
// without bubbles, address wrap, abort and asynchronous reset mid-load.
module tb_matrix_stream_loader;
  localparam int EW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, in_valid, in_ready;
  logic          mem_wr_en, busy, done, error;
  logic [AW-1:0] base_addr, mem_wr_addr;
  logic [EW-1:0] in_data, mem_wr_data;
  logic [4:0]    dim_m, dim_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [EW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            acc_q[$];

  matrix_stream_loader #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .MAX_DIM(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .dim_m(dim_m), .dim_n(dim_n), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every BRAM write with the cycle it appeared in.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_wr_en === 1'b1) begin
      wr_addr_q.push_back(mem_wr_addr);
      wr_data_q.push_back(mem_wr_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    acc_q.delete();
  endtask

  task automatic begin_load(input logic [AW-1:0] base);
    start     = 1'b1;
    base_addr = base;
    step();
  endtask

  // Offer one word and hold it until accepted; records the accepting cycle.
  task automatic send(input logic [EW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1 for word %h", in_ready, d);
      in_valid = 1'b0;
      return;
    end
    step();
    acc_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_data = '0;
    #12;
    checks++;
    if ({in_ready, mem_wr_en, done, error, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: ready,wr,done,err,busy=%b required 00000",
               {in_ready, mem_wr_en, done, error, busy});
    end
    checks++;
    if ({mem_wr_addr, mem_wr_data, dim_m, dim_n} !== '0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h data=%h m=%0d n=%0d required all 0",
               mem_wr_addr, mem_wr_data, dim_m, dim_n);
    end
    #1 rst_n = 1'b1;
    step();
    checks++;
    if ({in_ready, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: ready,busy=%b required 00", {in_ready, busy});
    end
  endtask

  task automatic test_basic();
    clear_log();
    begin_load(10'h040);
    checks++;
    if ({in_ready, busy} !== 2'b11) begin
      errors++;
      $display("FAIL basic_get_m: ready,busy=%b required 11", {in_ready, busy});
    end
    send(8'd2);
    send(8'd3);
    for (int i = 0; i < 6; i++) send(EW'(10 + i));
    checks++;
    if ({done, busy, mem_wr_en} !== 3'b101) begin
      errors++;
      $display("FAIL basic_done: done,busy,wr=%b required 101", {done, busy, mem_wr_en});
    end
    checks++;
    if (dim_m !== 5'd2 || dim_n !== 5'd3) begin
      errors++;
      $display("FAIL basic_dims: m=%0d n=%0d required 2 3", dim_m, dim_n);
    end
    step();
    checks++;
    if (wr_addr_q.size() != 6) begin
      errors++;
      $display("FAIL basic_count: writes=%0d required 6", wr_addr_q.size());
    end
    for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== AW'(10'h040 + i) || wr_data_q[i] !== EW'(10 + i) ||
          wr_cyc_q[i] != acc_q[i+2] || wr_cyc_q[i] != wr_cyc_q[0] + i) begin
        errors++;
        $display("FAIL basic_write%0d: addr=%h data=%0d cyc=%0d required %h %0d %0d",
                 i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], 10'h040 + i, 10 + i, acc_q[i+2]);
      end
    end
    start = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || dim_m !== 5'd2 || dim_n !== 5'd3) begin
      errors++;
      $display("FAIL basic_idle: done=%b m=%0d n=%0d required 0 2 3", done, dim_m, dim_n);
    end
  endtask

  task automatic test_full_bubbles();
    clear_log();
    begin_load(10'h100);
    send(8'd16);
    send(8'd16);
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b0;
      step();
      if (i == 255) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL full_early_done: done=%b required 0", done);
        end
      end
      send(EW'(i));
    end
    checks++;
    if (done !== 1'b1 || mem_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL full_done: done=%b wr=%b required 1 1", done, mem_wr_en);
    end
    step();
    checks++;
    if (wr_addr_q.size() != 256) begin
      errors++;
      $display("FAIL full_count: writes=%0d required 256", wr_addr_q.size());
    end
    for (int i = 0; i < 256 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== AW'(10'h100 + i) || wr_data_q[i] !== EW'(i) ||
          wr_cyc_q[i] != acc_q[i+2]) begin
        errors++;
        $display("FAIL full_write%0d: addr=%h data=%h cyc=%0d required %h %h %0d",
                 i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], 10'h100 + i, i[7:0], acc_q[i+2]);
      end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_header_errors();
    logic [EW-1:0] hm[3];
    logic [EW-1:0] hn[3];
    hm = '{8'd0, 8'd17, 8'd2};
    hn = '{8'd4, 8'd2, 8'h22};
    for (int k = 0; k < 3; k++) begin
      clear_log();
      begin_load(10'h000);
      send(hm[k]);
      send(hn[k]);
      step();
      checks++;
      if ({error, done, busy, in_ready} !== 4'b1000) begin
        errors++;
        $display("FAIL err%0d_state: err,done,busy,ready=%b required 1000",
                 k, {error, done, busy, in_ready});
      end
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (3) step();
      in_valid = 1'b0;
      checks++;
      if (wr_addr_q.size() != 0 || error !== 1'b1) begin
        errors++;
        $display("FAIL err%0d_hold: writes=%0d err=%b required 0 1", k, wr_addr_q.size(), error);
      end
      checks++;
      if (dim_m !== hm[k][4:0]) begin
        errors++;
        $display("FAIL err%0d_dim: m=%0d required %0d", k, dim_m, hm[k][4:0]);
      end
      start = 1'b0;
      step();
      checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL err%0d_clear: err=%b busy=%b required 0 0", k, error, busy);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr[4];
    exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    clear_log();
    begin_load(10'h3FE);
    send(8'd2);
    send(8'd2);
    for (int i = 1; i <= 4; i++) send(EW'(i));
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done: done=%b err=%b required 1 0", done, error);
    end
    step();
    checks++;
    if (wr_addr_q.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: writes=%0d required 4", wr_addr_q.size());
    end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== EW'(i + 1)) begin
        errors++;
        $display("FAIL wrap_write%0d: addr=%h data=%0d required %h %0d",
                 i, wr_addr_q[i], wr_data_q[i], exp_addr[i], i + 1);
      end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_abort();
    clear_log();
    begin_load(10'h200);
    send(8'd3);
    send(8'd3);
    send(8'hA0);
    send(8'hA1);
    in_valid = 1'b1;
    in_data  = 8'hA2;
    abort    = 1'b1;
    start    = 1'b0;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({mem_wr_en, busy, in_ready, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_state: wr,busy,ready,done=%b required 0000",
               {mem_wr_en, busy, in_ready, done});
    end
    checks++;
    if (dim_m !== 5'd3 || dim_n !== 5'd3) begin
      errors++;
      $display("FAIL abort_dims: m=%0d n=%0d required 3 3", dim_m, dim_n);
    end
    step();
    checks++;
    if (wr_addr_q.size() != 2 || wr_data_q[wr_data_q.size()-1] !== 8'hA1 ||
        wr_addr_q[wr_addr_q.size()-1] !== 10'h201) begin
      errors++;
      $display("FAIL abort_writes: writes=%0d required 2 ending A1@201", wr_addr_q.size());
    end
    clear_log();
    begin_load(10'h050);
    send(8'd1);
    send(8'd1);
    send(8'h77);
    checks++;
    if (done !== 1'b1 || dim_m !== 5'd1 || dim_n !== 5'd1) begin
      errors++;
      $display("FAIL abort_reload: done=%b m=%0d n=%0d required 1 1 1", done, dim_m, dim_n);
    end
    step();
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 10'h050 || wr_data_q[0] !== 8'h77) begin
      errors++;
      $display("FAIL abort_reload_write: writes=%0d required one 77@050", wr_addr_q.size());
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    begin_load(10'h000);
    send(8'd2);
    send(8'd2);
    send(8'h99);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_wr_en, done, error, busy} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_flags: ready,wr,done,err,busy=%b required 00000",
               {in_ready, mem_wr_en, done, error, busy});
    end
    checks++;
    if ({mem_wr_addr, mem_wr_data, dim_m, dim_n} !== '0) begin
      errors++;
      $display("FAIL rstmid_regs: addr=%h data=%h m=%0d n=%0d required all 0",
               mem_wr_addr, mem_wr_data, dim_m, dim_n);
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h33;
    #3 rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_idle: ready=%b busy=%b writes=%0d required 0 0 0",
               in_ready, busy, wr_addr_q.size());
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_bubbles();
    test_header_errors();
    test_wrap();
    test_abort();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Upstream feeder for the convolution engine and the other matrix operators.
- Accepts a byte stream (valid/ready) carrying a 2-byte dimension header (rows, cols) followed by rows*cols elements in row-major order.
- Validates the dimensions, writes the elements into BRAM starting at a caller-supplied base address, and reports the latched dimensions for the downstream operator's dim_m/dim_n inputs.

Parameters:
- ELEMENT_WIDTH, 8, width of one matrix element and one stream word.
- ADDR_WIDTH, 10, BRAM address width.
- MAX_DIM, 16, largest legal row/column count (1..MAX_DIM legal).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level request; a load begins when start=1 in S_IDLE
- abort  input  1  synchronous abort; returns to S_IDLE from any state
- base_addr  input  ADDR_WIDTH  BRAM destination of element (0,0); latched at start
- in_valid  input  1  stream word valid
- in_data  input  ELEMENT_WIDTH  stream word
- in_ready  output  1  block can accept a word this cycle
- mem_wr_en  output  1  BRAM write strobe
- mem_wr_addr  output  ADDR_WIDTH  BRAM write address
- mem_wr_data  output  ELEMENT_WIDTH  BRAM write data
- dim_m  output  5  latched row count
- dim_n  output  5  latched column count
- busy  output  1  high in any state except S_IDLE, S_DONE and S_ERR
- done  output  1  load completed successfully
- error  output  1  header rejected

Behaviour:
- Reset: state=S_IDLE; in_ready, mem_wr_en, done, error, busy=0; mem_wr_addr, mem_wr_data, dim_m, dim_n, element counter=0.
- Handshake:
  - in_ready is a combinational decode of state: 1 in S_GET_M, S_GET_N and S_LOAD; 0 otherwise.
  - A transfer occurs on a rising edge with in_valid & in_ready.
  - in_valid may drop at any time; bubbles are allowed and nothing advances without a transfer.
- State machine:
  - S_IDLE: done, error=0. If start (and !abort): latch base_addr, clear counter, go to S_GET_M.
  - S_GET_M: on transfer, dim_m <= in_data[4:0]; latch flag m_bad = (in_data==0 or in_data>MAX_DIM, evaluated on the full word). Go to S_GET_N.
  - S_GET_N: on transfer, dim_n <= in_data[4:0]; latch flag n_bad the same way. Go to S_CHECK.
  - S_CHECK (1 cycle, no transfer):
    - If m_bad or n_bad, go to S_ERR.
    - Otherwise total <= dim_m*dim_n (9-bit, max 256) and go to S_LOAD.
  - S_LOAD: on each transfer at counter idx:
    - Next cycle: mem_wr_en=1, mem_wr_addr=(base+idx) mod 2^ADDR_WIDTH, mem_wr_data=in_data.
    - Write latency is exactly 1 cycle after the accepting edge.
    - If idx==total-1, go to S_DONE; else idx+1.
    - mem_wr_en is 0 in any cycle not following a transfer.
  - S_DONE: done=1 (level). Return to S_IDLE when start=0. The final write strobe is asserted in the first S_DONE cycle.
  - S_ERR: error=1 (level); no BRAM writes. Return to S_IDLE when start=0.
- Abort:
  - Highest priority over all transitions: next state S_IDLE; mem_wr_en forced 0 in the following cycle, including a pending write.
  - A transfer coinciding with abort is discarded.
  - dim_m/dim_n keep their last values.
- Reset mid-load: immediate return to reset values; partially written BRAM contents are not restored.
- dim_m/dim_n hold their values after S_DONE until the next header is accepted; the downstream operator samples them while done=1.
- Address arithmetic: base+idx wraps silently at 2^ADDR_WIDTH; no error is raised.
- Words offered while in_ready=0 are ignored and not consumed.

Test Plan:
- start with base=0x040, stream 2,3,10,11,12,13,14,15 with in_valid continuous -> writes 10..15 to 0x040..0x045 on consecutive cycles, one cycle after each accept; dim_m=2, dim_n=3, done=1; busy=0 in S_DONE.
- 16x16 load from base=0x100, elements idx[7:0], in_valid toggling 1/0 every cycle -> 256 writes to 0x100..0x1FF with no duplicate or missing write; done after the last write.
- Header 0,4 -> error=1, no mem_wr_en pulse, in_ready=0 in S_ERR; header 17,2 -> error=1; drop start -> S_IDLE, error=0.
- base=0x3FE, header 2,2, data 1,2,3,4 -> writes to 0x3FE, 0x3FF, 0x000, 0x001; done=1.
- abort asserted on the cycle the 3rd element of a 3x3 load is accepted -> that element is not written, mem_wr_en=0 the next cycle, state S_IDLE; a following start with header 1,1 loads correctly.
- rst_n pulsed low mid-load (async, between clock edges) -> all outputs 0 immediately; in_ready=0 until a new start.
